// File: rtl/pc_sequencer.sv
// Next-PC selection with stall-deferred redirects, halt, and an optional trap/return path.
// Trap support (IRQ entry, EPC, ERET) is compiled in only when PC_SEQUENCER_IRQ_EN is defined.
module pc_sequencer #(
    parameter logic [31:0] IRQ_VECTOR   = 32'h0000_0080,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic signed [31:0] PC,
    input  logic               STALL,
    input  logic               HALT,
    input  logic               BR_TAKEN,
    input  logic signed [31:0] BR_OFFSET,
    input  logic               JUMP,
    input  logic [25:0]        J_TARGET,
    input  logic               JR,
    input  logic [31:0]        JR_ADDR,
    input  logic               IRQ,
    input  logic               ERET,
    output logic [31:0]        PC_NEXT,
    output logic               PC_WE,
    output logic [31:0]        EPC,
    output logic [1:0]         STATE
);

    typedef enum logic [1:0] {S_RUN = 2'd0, S_TRAP = 2'd1, S_HALTED = 2'd2} state_t;

    state_t      state;
    logic        pend;
    logic [31:0] pend_addr;

    logic [31:0] pc_plus4, br_addr, j_addr, sel, target;
    logic        redir, irq_take, eret_take;

    assign pc_plus4 = PC + 32'd4;
    assign br_addr  = pc_plus4 + (BR_OFFSET <<< 2);
    assign j_addr   = {pc_plus4[31:28], J_TARGET, 2'b00};
    assign redir    = JR | JUMP | BR_TAKEN;
    assign sel      = JR ? JR_ADDR : JUMP ? j_addr : BR_TAKEN ? br_addr : pc_plus4;
    // A redirect deferred by a stall overrides whatever arrives on release.
    assign target   = pend ? pend_addr : sel;
    assign STATE    = state;

`ifdef PC_SEQUENCER_IRQ_EN
    logic [31:0] epc_q;

    assign irq_take  = (state == S_RUN) && IRQ;
    assign eret_take = (state == S_TRAP) && ERET;
    assign EPC       = epc_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            epc_q <= '0;
        else if (irq_take && !STALL && !HALT)
            epc_q <= target;
    end
`else
    logic unused_irq;

    assign irq_take   = 1'b0;
    assign eret_take  = 1'b0;
    assign EPC        = '0;
    assign unused_irq = IRQ ^ ERET;
`endif

    always_comb begin
        PC_NEXT = PC;
        PC_WE   = 1'b0;
        if (RST) begin
            PC_NEXT = RESET_VECTOR;
        end else if (state != S_HALTED && !STALL && !HALT) begin
            PC_WE = 1'b1;
            if (eret_take)
                PC_NEXT = EPC;
            else if (irq_take)
                PC_NEXT = IRQ_VECTOR;
            else
                PC_NEXT = target;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_RUN;
            pend      <= 1'b0;
            pend_addr <= '0;
        end else if (state != S_HALTED) begin
            if (STALL) begin
                if (!pend && redir) begin
                    pend      <= 1'b1;
                    pend_addr <= sel;
                end
            end else begin
                pend <= 1'b0;
                if (HALT)
                    state <= S_HALTED;
                else if (eret_take)
                    state <= S_RUN;
                else if (irq_take)
                    state <= S_TRAP;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: spec-level reference model checked every cycle plus literal vectors.
module tb_pc_sequencer;

    localparam logic [31:0] IRQ_VECTOR   = 32'h0000_0080;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
`ifdef PC_SEQUENCER_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic               CLK = 1'b0;
    logic               RST;
    logic signed [31:0] PC;
    logic               STALL, HALT, BR_TAKEN, JUMP, JR, IRQ, ERET;
    logic signed [31:0] BR_OFFSET;
    logic [25:0]        J_TARGET;
    logic [31:0]        JR_ADDR;
    logic [31:0]        PC_NEXT, EPC;
    logic               PC_WE;
    logic [1:0]         STATE;

    int n_assert = 0;
    int n_fail   = 0;

    pc_sequencer #(.IRQ_VECTOR(IRQ_VECTOR), .RESET_VECTOR(RESET_VECTOR)) dut (
        .CLK(CLK), .RST(RST), .PC(PC), .STALL(STALL), .HALT(HALT),
        .BR_TAKEN(BR_TAKEN), .BR_OFFSET(BR_OFFSET), .JUMP(JUMP), .J_TARGET(J_TARGET),
        .JR(JR), .JR_ADDR(JR_ADDR), .IRQ(IRQ), .ERET(ERET),
        .PC_NEXT(PC_NEXT), .PC_WE(PC_WE), .EPC(EPC), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=run 1=trap 2=halted, plus deferred redirect and saved return address.
    int          m_mode = 0;
    bit          m_pend = 0;
    logic [31:0] m_paddr = '0;
    logic [31:0] m_epc = '0;

    initial begin
        int          n_mode;
        bit          n_pend;
        logic [31:0] n_paddr, n_epc, seq, want, tgt, e_next;
        logic        e_we;
        forever begin
            @(negedge CLK);
            seq = PC + 32'd4;
            if (JR)            want = JR_ADDR;
            else if (JUMP)     want = (seq & 32'hF000_0000) | (32'(J_TARGET) * 4);
            else if (BR_TAKEN) want = seq + BR_OFFSET * 4;
            else               want = seq;
            e_next = PC; e_we = 1'b0;
            if (RST) begin
                m_mode = 0; m_pend = 0; m_paddr = '0; m_epc = '0;
                e_next = RESET_VECTOR;
            end
            n_mode = m_mode; n_pend = m_pend; n_paddr = m_paddr; n_epc = m_epc;
            if (!RST && m_mode != 2) begin
                if (STALL) begin
                    if (!m_pend && (JR || JUMP || BR_TAKEN)) begin
                        n_pend = 1; n_paddr = want;
                    end
                end else begin
                    tgt = m_pend ? m_paddr : want;
                    n_pend = 0;
                    if (HALT) n_mode = 2;
                    else if (IRQ_EN && m_mode == 1 && ERET) begin
                        e_next = m_epc; e_we = 1; n_mode = 0;
                    end else if (IRQ_EN && m_mode == 0 && IRQ) begin
                        e_next = IRQ_VECTOR; e_we = 1; n_epc = tgt; n_mode = 1;
                    end else begin
                        e_next = tgt; e_we = 1;
                    end
                end
            end
            chk("model.pc_next", PC_NEXT, e_next);
            chk("model.pc_we", 32'(PC_WE), 32'(e_we));
            chk("model.state", 32'(STATE), 32'(m_mode));
            chk("model.epc", EPC, m_epc);
            @(posedge CLK);
            m_mode = n_mode; m_pend = n_pend; m_paddr = n_paddr; m_epc = n_epc;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        @(negedge CLK);
    endtask

    task automatic idle();
        STALL = 0; HALT = 0; BR_TAKEN = 0; BR_OFFSET = 0; JUMP = 0; J_TARGET = '0;
        JR = 0; JR_ADDR = '0; IRQ = 0; ERET = 0;
    endtask

    initial begin
        idle();
        RST = 1; PC = 32'h1234;
        settle();
        chk("reset.pc_next", PC_NEXT, 32'h0);
        chk("reset.pc_we", 32'(PC_WE), 32'h0);
        chk("reset.state", 32'(STATE), 32'h0);
        chk("reset.epc", EPC, 32'h0);
        step();
        step();

        RST = 0; PC = 32'h0;
        settle(); chk("first.seq", PC_NEXT, 32'h4); chk("first.we", 32'(PC_WE), 32'h1);
        step();

        PC = 32'h100; BR_TAKEN = 1; BR_OFFSET = -2;
        settle(); chk("br.neg", PC_NEXT, 32'h0FC); chk("br.we", 32'(PC_WE), 32'h1);
        step();

        PC = 32'h100; JR = 1; JR_ADDR = 32'h3000; JUMP = 1; J_TARGET = 26'h10;
        settle(); chk("prio.jr", PC_NEXT, 32'h3000);
        step();
        JR = 0; PC = 32'h1000_0000;
        settle(); chk("prio.jump", PC_NEXT, 32'h1000_0044 - 32'h4);
        step();
        idle();

        PC = 32'hFFFF_FFFC;
        settle(); chk("wrap", PC_NEXT, 32'h0);
        step();

        PC = 32'h200; STALL = 1; JUMP = 1; J_TARGET = 26'h40;
        settle(); chk("stall1.pc_next", PC_NEXT, 32'h200); chk("stall1.we", 32'(PC_WE), 32'h0);
        step();
        JUMP = 0; BR_TAKEN = 1; BR_OFFSET = 8;
        settle(); chk("stall2.we", 32'(PC_WE), 32'h0);
        step();
        BR_TAKEN = 0;
        settle(); chk("stall3.we", 32'(PC_WE), 32'h0);
        step();
        STALL = 0; JR = 1; JR_ADDR = 32'h999;
        settle(); chk("release.pc_next", PC_NEXT, 32'h100); chk("release.we", 32'(PC_WE), 32'h1);
        step();
        idle(); PC = 32'h100;
        settle(); chk("after_release", PC_NEXT, 32'h104);
        step();

`ifdef PC_SEQUENCER_IRQ_EN
        PC = 32'h40; IRQ = 1;
        settle(); chk("irq.pc_next", PC_NEXT, 32'h80); chk("irq.we", 32'(PC_WE), 32'h1);
        step();
        PC = 32'h80;
        settle(); chk("trap.state", 32'(STATE), 32'h1); chk("trap.epc", EPC, 32'h44);
        chk("trap.seq", PC_NEXT, 32'h84);
        step();
        IRQ = 0; ERET = 1; PC = 32'h84;
        settle(); chk("eret.pc_next", PC_NEXT, 32'h44);
        step();
        ERET = 0; PC = 32'h44;
        settle(); chk("eret.state", 32'(STATE), 32'h0);
        step();
        PC = 32'h40; IRQ = 1;
        step();
        IRQ = 0; RST = 1;
        settle(); chk("rst_trap.epc", EPC, 32'h0); chk("rst_trap.state", 32'(STATE), 32'h0);
        step();
        RST = 0;
        step();
`else
        PC = 32'h40; IRQ = 1; ERET = 1;
        settle(); chk("noirq.pc_next", PC_NEXT, 32'h44);
        step();
        settle(); chk("noirq.state", 32'(STATE), 32'h0); chk("noirq.epc", EPC, 32'h0);
        step();
        idle();
`endif

        PC = 32'h300; HALT = 1; IRQ = 1;
        settle(); chk("halt.pc_next", PC_NEXT, 32'h300); chk("halt.we", 32'(PC_WE), 32'h0);
        step();
        idle(); PC = 32'h500; JR = 1; JR_ADDR = 32'h700;
        settle(); chk("halted.state", 32'(STATE), 32'h2); chk("halted.we", 32'(PC_WE), 32'h0);
        chk("halted.pc_next", PC_NEXT, 32'h500);
        step();
        idle();
        settle(); chk("halted2.state", 32'(STATE), 32'h2);
        step();

        RST = 1;
        settle(); chk("rst.pc_next", PC_NEXT, 32'h0); chk("rst.state", 32'(STATE), 32'h0);
        step();
        RST = 0;
        settle(); chk("rst.exit", PC_NEXT, 32'h504);
        step();

        PC = 32'h200; STALL = 1; JUMP = 1; J_TARGET = 26'h40;
        step();
        idle(); RST = 1;
        step();
        RST = 0;
        settle(); chk("rst_stall.discard", PC_NEXT, 32'h204);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter IRQ_VECTOR, default 32'h0000_0080, trap entry address.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, PC_NEXT value while in reset.
REQ-003 SHALL have port CLK  in  1  rising-edge clock.
REQ-004 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port PC  in  32  current PC from the PC register (signed).
REQ-006 SHALL have port STALL  in  1  hold PC this cycle.
REQ-007 SHALL have port HALT  in  1  halt instruction retiring.
REQ-008 SHALL have port BR_TAKEN  in  1  conditional branch taken.
REQ-009 SHALL have port BR_OFFSET  in  32  signed word offset.
REQ-010 SHALL have port JUMP  in  1  absolute jump.
REQ-011 SHALL have port J_TARGET  in  26  jump word index.
REQ-012 SHALL have port JR  in  1  register jump.
REQ-013 SHALL have port JR_ADDR  in  32  register jump byte address.
REQ-014 SHALL have port IRQ  in  1  level interrupt request.
REQ-015 SHALL have port ERET  in  1  return from trap.
REQ-016 SHALL have port PC_NEXT  out  32  next PC to the PC register (combinational).
REQ-017 SHALL have port PC_WE  out  1  PC update valid this cycle.
REQ-018 SHALL have port EPC  out  32  saved return address (registered).
REQ-019 SHALL have port STATE  out  2  RUN=0, TRAP=1, HALTED=2; 3 unused.

Function
REQ-020 SHALL compute seq = PC+4, br = PC+4+(BR_OFFSET<<2), j = {PC_plus4[31:28], J_TARGET, 2'b00}, all modulo 2^32, with wrap-around and no overflow flag.
REQ-021 SHALL select the redirect by priority JR > JUMP > BR_TAKEN > seq.
REQ-022 SHALL, with STALL=1 and not HALTED, drive PC_NEXT=PC and PC_WE=0, and latch any asserted redirect (target address plus pending flag) if none is already pending; the first pending redirect wins.
REQ-023 SHALL, on the first cycle with STALL=0, use the pending target in place of the selected redirect and clear the pending flag; redirect inputs that cycle are ignored.
REQ-024 SHALL, in RUN with STALL=0, drive PC_NEXT equal to the selected target and PC_WE=1.
REQ-025 SHALL, in RUN with STALL=0 and HALT=1, drive PC_NEXT=PC and PC_WE=0, and go to HALTED next edge.
REQ-026 SHALL, in HALTED, drive PC_NEXT=PC and PC_WE=0 and ignore all inputs; exit is by RST only.
REQ-027 SHALL give HALT priority over IRQ in the same cycle.
REQ-028 SHALL give STALL priority over HALT and IRQ; those are sampled only when STALL=0.
REQ-029 SHALL treat the transition to RUN after RST deassertion as a zero-latency update: first edge loads seq.

Reset
REQ-030 SHALL, while RST=1, hold STATE=RUN, EPC=0, pending flag=0, PC_WE=0, PC_NEXT=RESET_VECTOR.
REQ-031 SHALL, on RST mid-stall or mid-trap, discard pending redirect and EPC immediately (asynchronously).

Configuration
REQ-032 SHALL compile trap support only when macro PC_SEQUENCER_IRQ_EN is defined.
REQ-033 SHALL, with PC_SEQUENCER_IRQ_EN defined, in RUN with STALL=0, HALT=0, IRQ=1, drive PC_NEXT=IRQ_VECTOR, PC_WE=1, load EPC with the target that would have been used, clear pending, and go to TRAP.
REQ-034 SHALL, with PC_SEQUENCER_IRQ_EN defined, in TRAP ignore IRQ; ERET with STALL=0 drives PC_NEXT=EPC, PC_WE=1, STATE to RUN; otherwise TRAP sequences like RUN (HALT still goes to HALTED).
REQ-035 SHALL, without PC_SEQUENCER_IRQ_EN, ignore IRQ and ERET, tie EPC to 0, and never reach TRAP.

Verification
REQ-036 SHALL cover: PC=0x100, BR_TAKEN=1, BR_OFFSET=-2 -> PC_NEXT=0x0FC, PC_WE=1.
REQ-037 SHALL cover: PC=0x200, STALL=1 with JUMP=1, J_TARGET=0x40 for one cycle; STALL 3 cycles; release -> PC_WE=0 during stall, then PC_NEXT=0x100.
REQ-038 SHALL cover: PC=0xFFFF_FFFC, no redirect -> PC_NEXT=0x0000_0000 (wrap).
REQ-039 SHALL cover (IRQ_EN): PC=0x40, IRQ=1 -> PC_NEXT=0x80, EPC=0x44, STATE=1; then ERET -> PC_NEXT=0x44, STATE=0.
REQ-040 SHALL cover: HALT=1 and IRQ=1 together -> STATE=2, PC_WE=0 thereafter; RST pulse -> PC_NEXT=0, STATE=0.
